// File: rtl/clawgame_pkg.sv
// Shared types and widths for the claw game round sequencer.
//
// Contents:
//   state_e  : game state enum with its 2-bit output encoding
//   TimeW    : width of time_left, score and high_score
//   ReadyW   : width of the get-ready countdown
package clawgame_pkg;

  localparam int unsigned TimeW  = 16;
  localparam int unsigned ReadyW = 4;

  // The encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StPlaying = 2'd2,
    StOver    = 2'd3
  } state_e;

endpackage

// File: rtl/clawgame_sec_prescaler.sv
// Game-second prescaler: counts clock cycles 0..CLK_HZ-1 while enabled and
// flags the last cycle of each game second.
//
// Parameters:
//   CLK_HZ : clock cycles per game second (>= 2)
// Ports:
//   clock  in  : system clock
//   reset  in  : synchronous, active-high
//   enable in  : count while high; counter is held at 0 while low
//   clear  in  : force the counter back to 0 on the next edge
//   tick   out : combinational, high when the count is CLK_HZ-1 and enabled
module clawgame_sec_prescaler #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = enable && (count_q == CntLast);

  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear || !enable || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clawgame_round_ctrl.sv
// Claw game round sequencer: game state machine (idle, get-ready countdown,
// playing, game over), round timer, score counter and optional high score.
//
// Build option:
//   CLAWGAME_HIGH_SCORE_EN : when defined, high_score tracks the best final
//                            score since reset; otherwise it is tied to 0.
// Parameters:
//   CLK_HZ        : clock cycles per game second (>= 2)
//   ROUND_SECONDS : playing phase length, 1..65535
//   READY_SECONDS : get-ready countdown length, 0..15
// Ports:
//   clock        in  : system clock
//   reset        in  : synchronous, active-high
//   start_btn    in  : debounced level, rising edge starts a round
//   score_btn    in  : debounced level, rising edge scores a point
//   game_active  out : high only while playing
//   ready_active out : high only during the get-ready countdown
//   game_over    out : one-cycle pulse on entry to the game-over state
//   state        out : IDLE=0, ARMED=1, PLAYING=2, OVER=3
//   ready_left   out : get-ready seconds remaining
//   time_left    out : round seconds remaining
//   score        out : current round score
//   high_score   out : best final score since reset
module clawgame_round_ctrl
  import clawgame_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned READY_SECONDS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              score_btn,
  output logic              game_active,
  output logic              ready_active,
  output logic              game_over,
  output logic [1:0]        state,
  output logic [ReadyW-1:0] ready_left,
  output logic [TimeW-1:0]  time_left,
  output logic [TimeW-1:0]  score,
  output logic [TimeW-1:0]  high_score
);

  localparam logic [TimeW-1:0]  RoundLoad = TimeW'(ROUND_SECONDS);
  localparam logic [ReadyW-1:0] ReadyLoad = ReadyW'(READY_SECONDS);
  // A zero-length countdown skips ARMED entirely.
  localparam state_e StartState = (READY_SECONDS == 0) ? StPlaying : StArmed;

  state_e            state_q, state_d;
  logic [ReadyW-1:0] ready_q, ready_d;
  logic [TimeW-1:0]  time_q, time_d;
  logic [TimeW-1:0]  score_q, score_d;
  logic              start_prev_q, score_prev_q;
  logic              game_active_q, ready_active_q, game_over_q;
  logic              game_over_d;
  logic              start_rise, score_rise;
  logic              presc_en, presc_clear, sec_tick;

  // Previous samples reset high so a button held through reset is not an edge.
  assign start_rise = start_btn && !start_prev_q;
  assign score_rise = score_btn && !score_prev_q;

  assign presc_en = (state_q == StArmed) || (state_q == StPlaying);

  clawgame_sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(presc_en),
    .clear (presc_clear),
    .tick  (sec_tick)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    time_d      = time_q;
    score_d     = score_q;
    presc_clear = 1'b0;
    game_over_d = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          state_d     = StartState;
          score_d     = '0;
          time_d      = RoundLoad;
          ready_d     = ReadyLoad;
          presc_clear = 1'b1;
        end
      end

      StArmed: begin
        if (sec_tick) begin
          if (ready_q <= ReadyW'(1)) begin
            state_d     = StPlaying;
            ready_d     = '0;
            presc_clear = 1'b1;
          end else begin
            ready_d = ready_q - ReadyW'(1);
          end
        end
      end

      StPlaying: begin
        // Counted even on the final tick, so it reaches the high-score compare.
        if (score_rise && (score_q != '1)) begin
          score_d = score_q + TimeW'(1);
        end
        if (sec_tick) begin
          if (time_q <= TimeW'(1)) begin
            state_d     = StOver;
            time_d      = '0;
            game_over_d = 1'b1;
          end else begin
            time_d = time_q - TimeW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      ready_q        <= '0;
      time_q         <= '0;
      score_q        <= '0;
      start_prev_q   <= 1'b1;
      score_prev_q   <= 1'b1;
      game_active_q  <= 1'b0;
      ready_active_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      time_q         <= time_d;
      score_q        <= score_d;
      start_prev_q   <= start_btn;
      score_prev_q   <= score_btn;
      // Flags are decoded from the next state so they change with state.
      game_active_q  <= (state_d == StPlaying);
      ready_active_q <= (state_d == StArmed);
      game_over_q    <= game_over_d;
    end
  end

`ifdef CLAWGAME_HIGH_SCORE_EN
  logic [TimeW-1:0] high_score_q;

  // Compare against score_d so a same-cycle final increment is included.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_score_q <= '0;
    end else if (game_over_d && (score_d > high_score_q)) begin
      high_score_q <= score_d;
    end
  end

  assign high_score = high_score_q;
`else
  assign high_score = '0;
`endif

  assign state        = state_q;
  assign ready_left   = ready_q;
  assign time_left    = time_q;
  assign score        = score_q;
  assign game_active  = game_active_q;
  assign ready_active = ready_active_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_clawgame_round_ctrl.sv
// Self-checking bench for clawgame_round_ctrl with CLK_HZ=4, ROUND_SECONDS=3,
// READY_SECONDS=2. Directed scenarios use fixed expected values; the random
// scenario compares every cycle against a phase/elapsed-cycle model.
module tb_clawgame_round_ctrl;

  localparam int Clk   = 4;
  localparam int Round = 3;
  localparam int Ready = 2;
`ifdef CLAWGAME_HIGH_SCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0;
  logic        score_btn = 1'b0;
  logic        game_active, ready_active, game_over;
  logic [1:0]  state;
  logic [3:0]  ready_left;
  logic [15:0] time_left, score, high_score;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase (0 idle, 1 get-ready, 2 playing, 3 over) plus the
  // number of cycles spent in that phase.
  int m_phase = 0;
  int m_el    = 0;
  int m_score = 0;
  int m_hi    = 0;
  bit m_go    = 1'b0;
  bit m_ps    = 1'b1;
  bit m_pss   = 1'b1;

  clawgame_round_ctrl #(
    .CLK_HZ(Clk),
    .ROUND_SECONDS(Round),
    .READY_SECONDS(Ready)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_btn(start_btn),
    .score_btn(score_btn),
    .game_active(game_active),
    .ready_active(ready_active),
    .game_over(game_over),
    .state(state),
    .ready_left(ready_left),
    .time_left(time_left),
    .score(score),
    .high_score(high_score)
  );

  always #5 clock = ~clock;

  task automatic model_update();
    bit sr, br;
    sr = start_btn && !m_ps;
    br = score_btn && !m_pss;
    m_go = 1'b0;
    if (reset) begin
      m_phase = 0; m_el = 0; m_score = 0; m_hi = 0; m_ps = 1'b1; m_pss = 1'b1;
      return;
    end
    m_ps  = start_btn;
    m_pss = score_btn;
    case (m_phase)
      0, 3: if (sr) begin
        m_phase = (Ready == 0) ? 2 : 1;
        m_el    = 0;
        m_score = 0;
      end
      1: begin
        m_el++;
        if (m_el == Ready * Clk) begin m_phase = 2; m_el = 0; end
      end
      default: begin
        if (br && m_score < 65535) m_score++;
        m_el++;
        if (m_el == Round * Clk) begin
          m_phase = 3;
          m_el    = 0;
          m_go    = 1'b1;
          if (m_score > m_hi) m_hi = m_score;
        end
      end
    endcase
  endtask

  function automatic logic [56:0] exp_vec();
    int rl, tl;
    rl = (m_phase == 1) ? Ready - m_el / Clk : 0;
    tl = (m_phase == 1) ? Round : (m_phase == 2) ? Round - m_el / Clk : 0;
    return {2'(m_phase), m_phase == 2, m_phase == 1, m_go, 4'(rl), 16'(tl),
            16'(m_score), HsEn ? 16'(m_hi) : 16'd0};
  endfunction

  // Advance one clock; outputs are stable and sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  // Precondition: the start step was just taken (cycle N+1). Runs to OVER at
  // N+21 with n score presses early in PLAYING.
  task automatic play_rest(input int n);
    for (int i = 0; i < 20; i++) begin
      score_btn = (i >= 8) && (i < 8 + 2 * n) && (((i - 8) % 2) == 0);
      step();
    end
    score_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_btn = 1'b0; score_btn = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_tests++;
    if (state !== 2'd0 || game_active !== 1'b0 || ready_active !== 1'b0 || game_over !== 1'b0 ||
        ready_left !== 4'd0 || time_left !== 16'd0 || score !== 16'd0 || high_score !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: st=%0d ga=%0b ra=%0b go=%0b rl=%0d tl=%0d sc=%0d hs=%0d want all 0",
               state, game_active, ready_active, game_over, ready_left, time_left, score,
               high_score);
    end
  endtask

  task automatic test_final_tick_score();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    repeat (19) step();
    score_btn = 1'b1;
    step();
    n_tests++;
    if (state !== 2'd3 || game_over !== 1'b1 || score !== 16'd1 ||
        high_score !== (HsEn ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL final_tick_score: st=%0d go=%0b sc=%0d hs=%0d want 3/1/1/%0d",
               state, game_over, score, high_score, HsEn ? 1 : 0);
    end
    score_btn = 1'b0;
    step();
  endtask

  task automatic test_round_timing();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    n_tests++;
    if (state !== 2'd1 || ready_left !== 4'd2 || ready_active !== 1'b1 || time_left !== 16'd3) begin
      n_fail++;
      $display("FAIL armed_entry: st=%0d rl=%0d ra=%0b tl=%0d want 1/2/1/3",
               state, ready_left, ready_active, time_left);
    end
    score_btn = 1'b1; step(); score_btn = 1'b0; step();
    n_tests++;
    if (score !== 16'd0) begin
      n_fail++;
      $display("FAIL score_in_armed: score=%0d want 0", score);
    end
    repeat (5) step();
    n_tests++;
    if (state !== 2'd1 || ready_left !== 4'd1) begin
      n_fail++;
      $display("FAIL armed_last_cycle: st=%0d rl=%0d want 1/1", state, ready_left);
    end
    step();
    n_tests++;
    if (state !== 2'd2 || time_left !== 16'd3 || ready_left !== 4'd0 || game_active !== 1'b1 ||
        ready_active !== 1'b0) begin
      n_fail++;
      $display("FAIL playing_entry: st=%0d tl=%0d rl=%0d ga=%0b ra=%0b want 2/3/0/1/0",
               state, time_left, ready_left, game_active, ready_active);
    end
    repeat (3) begin score_btn = 1'b1; step(); score_btn = 1'b0; step(); end
    start_btn = 1'b1; step(); start_btn = 1'b0; step();
    n_tests++;
    if (state !== 2'd2 || score !== 16'd3 || time_left !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_play: st=%0d sc=%0d tl=%0d want 2/3/1", state, score, time_left);
    end
    repeat (3) step();
    n_tests++;
    if (state !== 2'd2 || game_over !== 1'b0 || time_left !== 16'd1) begin
      n_fail++;
      $display("FAIL play_last_cycle: st=%0d go=%0b tl=%0d want 2/0/1", state, game_over, time_left);
    end
    step();
    n_tests++;
    if (state !== 2'd3 || game_over !== 1'b1 || time_left !== 16'd0 || game_active !== 1'b0 ||
        high_score !== (HsEn ? 16'd3 : 16'd0)) begin
      n_fail++;
      $display("FAIL over_entry: st=%0d go=%0b tl=%0d ga=%0b hs=%0d want 3/1/0/0/%0d",
               state, game_over, time_left, game_active, high_score, HsEn ? 3 : 0);
    end
    step();
    n_tests++;
    if (game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL game_over_pulse: go=%0b want 0", game_over);
    end
    score_btn = 1'b1; step(); score_btn = 1'b0; step();
    n_tests++;
    if (state !== 2'd3 || score !== 16'd3 || time_left !== 16'd0) begin
      n_fail++;
      $display("FAIL score_in_over: st=%0d sc=%0d tl=%0d want 3/3/0", state, score, time_left);
    end
  endtask

  task automatic test_high_score();
    start_btn = 1'b1; step(); start_btn = 1'b0;
    play_rest(5);
    n_tests++;
    if (state !== 2'd3 || score !== 16'd5 || high_score !== (HsEn ? 16'd5 : 16'd0)) begin
      n_fail++;
      $display("FAIL round1_high: st=%0d sc=%0d hs=%0d want 3/5/%0d",
               state, score, high_score, HsEn ? 5 : 0);
    end
    start_btn = 1'b1; step(); start_btn = 1'b0;
    n_tests++;
    if (state !== 2'd1 || score !== 16'd0 || time_left !== 16'd3) begin
      n_fail++;
      $display("FAIL restart_clear: st=%0d sc=%0d tl=%0d want 1/0/3", state, score, time_left);
    end
    play_rest(2);
    n_tests++;
    if (state !== 2'd3 || score !== 16'd2 || high_score !== (HsEn ? 16'd5 : 16'd0)) begin
      n_fail++;
      $display("FAIL round2_high: st=%0d sc=%0d hs=%0d want 3/2/%0d",
               state, score, high_score, HsEn ? 5 : 0);
    end
  endtask

  task automatic test_reset_mid_play();
    bit saw_go;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    repeat (12) step();
    reset = 1'b1; start_btn = 1'b1;
    step();
    n_tests++;
    if (state !== 2'd0 || game_active !== 1'b0 || ready_active !== 1'b0 || game_over !== 1'b0 ||
        ready_left !== 4'd0 || time_left !== 16'd0 || score !== 16'd0 || high_score !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_play: st=%0d ga=%0b go=%0b tl=%0d sc=%0d hs=%0d want all 0",
               state, game_active, game_over, time_left, score, high_score);
    end
    reset = 1'b0;
    saw_go = 1'b0;
    repeat (4) begin step(); saw_go |= game_over; end
    n_tests++;
    if (state !== 2'd0 || saw_go) begin
      n_fail++;
      $display("FAIL start_held_through_reset: st=%0d saw_go=%0b want 0/0", state, saw_go);
    end
    start_btn = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [56:0] want;
    logic [56:0] got;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
      score_btn = 1'($urandom_range(0, 1));
      step();
      want = exp_vec();
      got  = {state, game_active, ready_active, game_over, ready_left, time_left, score,
              high_score};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got=%h want=%h", cyc, got, want);
      end
    end
    reset = 1'b0; start_btn = 1'b0; score_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_final_tick_score();
    test_round_timing();
    test_high_score();
    test_reset_mid_play();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clawgame_round_ctrl.md
# clawgame_round_ctrl

Round sequencer for the claw game. It owns the game state machine (idle, get-ready countdown, playing, game over), the round timer, the score counter and the optional high-score register. It replaces free-running timer and score logic with a start-triggered, repeatable round. It sits between the debounced button inputs and the LED display controller, which consumes `time_left`, `score` and `high_score`.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per game second; must be ≥ 2.
- `ROUND_SECONDS`, default 60: length of the playing phase; 1..65535.
- `READY_SECONDS`, default 3: length of the get-ready countdown; 0..15.
- `clock  in  1`: system clock.
- `reset  in  1`: synchronous, active-high.
- `start_btn  in  1`: debounced level; its rising edge starts a round.
- `score_btn  in  1`: debounced level; its rising edge scores one point.
- `game_active  out  1`: high only in PLAYING.
- `ready_active  out  1`: high only in ARMED.
- `game_over  out  1`: one-cycle pulse on entry to OVER.
- `state  out  2`: encoding IDLE=0, ARMED=1, PLAYING=2, OVER=3.
- `ready_left  out  4`: get-ready seconds remaining.
- `time_left  out  16`: round seconds remaining.
- `score  out  16`: current round score.
- `high_score  out  16`: best score since reset.

## Operation
- Edge detect: the previous sample of each button is registered. Both previous-sample registers reset to 1, so a button held through reset produces no edge.
- IDLE:
  - Start edge → ARMED.
  - On the transition: score ← 0, time_left ← ROUND_SECONDS, ready_left ← READY_SECONDS, prescaler ← 0.
  - If READY_SECONDS = 0, go directly to PLAYING instead, with the same loads.
- ARMED:
  - Each second tick decrements ready_left.
  - Tick while ready_left = 1 → PLAYING; ready_left ← 0; prescaler ← 0.
- PLAYING:
  - Each tick decrements time_left.
  - Tick while time_left = 1 → OVER; time_left ← 0; game_over pulses for one cycle.
  - Score edge → score + 1, saturating at 16'hFFFF.
- OVER:
  - score and time_left hold.
  - Start edge → ARMED, with the same loads as from IDLE.
- Ignored events:
  - Start edges in ARMED and PLAYING.
  - Score edges in IDLE, ARMED and OVER.
- Simultaneous events: a score edge in the same cycle as the final PLAYING tick is counted.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in ARMED and PLAYING; held at 0 elsewhere.
  - The tick is combinational: count == CLK_HZ-1. The counter wraps to 0 on that cycle.
- Reset mid-round aborts the round immediately. There is no game_over pulse.

## Timing
- Reset values:
  - state IDLE.
  - game_active, ready_active, game_over all 0.
  - ready_left 0, time_left 0, score 0, high_score 0.
  - Prescaler 0.
- Latency and phase durations:
  - Start edge sampled in cycle N → state ARMED in cycle N+1.
  - ARMED lasts exactly READY_SECONDS × CLK_HZ cycles.
  - PLAYING lasts exactly ROUND_SECONDS × CLK_HZ cycles.
- Flag outputs: game_active, ready_active and game_over are registered and change in the same cycle as state.
- Score latency: a score edge in cycle N is visible on score in cycle N+1.
- high_score:
  - Updates in the first OVER cycle (the same cycle as game_over) if score > high_score.
  - It compares the final score, including any same-cycle increment.

## Configuration
- Macro: `CLAWGAME_HIGH_SCORE_EN`.
- Defined: the high_score register and comparator are built as described above.
- Undefined: high_score is tied to 0 and no register is inferred. All other behaviour is identical.

## Structure
- `clawgame_pkg` holds:
  - the state enum (IDLE/ARMED/PLAYING/OVER and their 2-bit encoding);
  - the 16-bit score/time width constant;
  - the 4-bit ready width constant.
- Sub-module `clawgame_sec_prescaler` provides the CLK_HZ counter. Ports: clock, reset, enable, clear, tick.

## Test plan
All scenarios use CLK_HZ=4, ROUND_SECONDS=3, READY_SECONDS=2.
- Reset, then a start edge at cycle N:
  - ARMED at N+1, ready_left=2.
  - PLAYING at N+9 with time_left=3.
  - OVER at N+21 with a one-cycle game_over pulse; time_left=0.
- Three score edges during PLAYING → score=3. A score edge in ARMED and one in OVER → score unchanged.
- Start edge mid-PLAYING → ignored; time_left keeps decrementing.
- Score edge on the final tick cycle → counted; with `CLAWGAME_HIGH_SCORE_EN` defined, high_score equals that final score.
- Round 1 scores 5, round 2 scores 2:
  - high_score is 5 after both rounds.
  - Second start from OVER clears score to 0.
  - Without the macro, high_score stays 0 throughout.
- Reset asserted mid-PLAYING → IDLE next cycle, all outputs 0, no game_over. start_btn held high across reset release → remains IDLE.
